// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch / program-counter stage.
package fetch_pc_unit_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_INC_DEFAULT   = 32'd4;

    // FETCH: request outstanding; SQUASH: wrong-path reply pending;
    // BUFFERED: skid register full, no request issued.
    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_SQUASH   = 2'd1,
        ST_BUFFERED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_target_adder.sv
// Branch target formation: RedirectBase + BranchOffset, wrapping mod 2^32.
module pc_target_adder
    import fetch_pc_unit_pkg::*;
(
    input  logic [WORD_W-1:0] base,
    input  logic [WORD_W-1:0] offset,
    output logic [WORD_W-1:0] target
);

    // Plain modular add; carry-out is intentionally discarded.
    always_comb begin
        target = base + offset;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, instruction-fetch handshake, IF/ID register, wrong-path
// squash and one-entry skid buffer.
//
// Memory handshake: ImemReq is a level request for ImemAddr, high only in
// FETCH while out of reset. ImemReady is a single-cycle pulse; ImemData is
// valid only in that cycle. Exactly one reply follows each issued address,
// so a redirect taken while a reply is still owed waits in SQUASH to drop it.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [WORD_W-1:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Redirect,
    input  logic [WORD_W-1:0] RedirectBase,
    input  logic [WORD_W-1:0] BranchOffset,
    output logic [WORD_W-1:0] ImemAddr,
    output logic              ImemReq,
    input  logic              ImemReady,
    input  logic [WORD_W-1:0] ImemData,
    output logic [WORD_W-1:0] IfIdInstr,
    output logic [WORD_W-1:0] IfIdPCPlus4,
    output logic              IfIdValid,
    output logic [1:0]        dbg_state
);

    fetch_state_e      state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pending_pc;
    logic [WORD_W-1:0] skid_instr;
    logic [WORD_W-1:0] skid_pc_plus4;
    logic [WORD_W-1:0] target;
    logic [WORD_W-1:0] pc_plus4;

    pc_target_adder u_target_adder (
        .base   (RedirectBase),
        .offset (BranchOffset),
        .target (target)
    );

    // Sequential increment and the externally visible views of the state.
    always_comb begin
        pc_plus4  = pc + PC_INC;
        ImemAddr  = pc;
        ImemReq   = Rst && (state == ST_FETCH);
        dbg_state = state;
    end

    // Fetch FSM with PC, pending target, skid and IF/ID registers.
    // Edge priority: reset, then redirect, then stall, then normal flow.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state         <= ST_FETCH;
            pc            <= RESET_PC;
            pending_pc    <= RESET_PC;
            skid_instr    <= '0;
            skid_pc_plus4 <= '0;
            IfIdInstr     <= '0;
            IfIdPCPlus4   <= '0;
            IfIdValid     <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (Redirect) begin
                        IfIdValid <= 1'b0;
                        if (ImemReady) begin
                            // Reply arrived with the redirect: drop it and go.
                            pc <= target;
                        end else begin
                            // Reply still owed for the old PC: wait it out.
                            pending_pc <= target;
                            state      <= ST_SQUASH;
                        end
                    end else if (Stall) begin
                        if (ImemReady) begin
                            skid_instr    <= ImemData;
                            skid_pc_plus4 <= pc_plus4;
                            state         <= ST_BUFFERED;
                        end
                    end else if (ImemReady) begin
                        IfIdInstr   <= ImemData;
                        IfIdPCPlus4 <= pc_plus4;
                        IfIdValid   <= 1'b1;
                        pc          <= pc_plus4;
                    end else begin
                        IfIdValid <= 1'b0;
                    end
                end

                ST_SQUASH: begin
                    IfIdValid <= 1'b0;
                    if (Redirect) begin
                        pending_pc <= target;
                    end
                    if (ImemReady) begin
                        // Latest redirect wins, including one in this cycle.
                        pc    <= Redirect ? target : pending_pc;
                        state <= ST_FETCH;
                    end
                end

                ST_BUFFERED: begin
                    if (Redirect) begin
                        pc        <= target;
                        IfIdValid <= 1'b0;
                        state     <= ST_FETCH;
                    end else if (!Stall) begin
                        IfIdInstr   <= skid_instr;
                        IfIdPCPlus4 <= skid_pc_plus4;
                        IfIdValid   <= 1'b1;
                        pc          <= pc_plus4;
                        state       <= ST_FETCH;
                    end
                end

                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule
